sim_console: RTL

Memory-mapped console and halt peripheral on the MIPS32 data bus, directly downstream of the CPU core inside `top`. Buffers characters written by the program in a small FIFO, streams them out over a valid/ready byte port to the simulation bench, and latches a halt request with an exit code so the bench ends the run on program completion instead of on a fixed timeout.

---
 rtl/sim_console_pkg.sv | 34 +++
 rtl/sim_console_sync_fifo.sv | 67 ++++++
 rtl/sim_console.sv | 120 ++++++++++++
 3 files changed

// File: rtl/sim_console_pkg.sv
// Shared constants for the simulation console peripheral: register offsets
// (word index within the 16-byte window) and STATUS bit positions.
package sim_console_pkg;

    localparam logic [1:0] OFS_TXDATA = 2'd0;
    localparam logic [1:0] OFS_STATUS = 2'd1;
    localparam logic [1:0] OFS_HALT   = 2'd2;
    localparam logic [1:0] OFS_CLEAR  = 2'd3;

    localparam int STAT_COUNT_LSB = 0;
    localparam int STAT_FULL_BIT  = 8;
    localparam int STAT_EMPTY_BIT = 9;
    localparam int STAT_OVF_BIT   = 10;
    localparam int STAT_HALT_BIT  = 11;

    // Assemble the STATUS word from its fields; unused bits read as zero.
    function automatic logic [31:0] pack_status(
        input logic [7:0] count,
        input logic       full,
        input logic       empty,
        input logic       ovf,
        input logic       halted
    );
        logic [31:0] s;
        s = '0;
        s[STAT_COUNT_LSB +: 8] = count;
        s[STAT_FULL_BIT]       = full;
        s[STAT_EMPTY_BIT]      = empty;
        s[STAT_OVF_BIT]        = ovf;
        s[STAT_HALT_BIT]       = halted;
        return s;
    endfunction

endpackage

// File: rtl/sim_console_sync_fifo.sv
// Generic synchronous FIFO with registered storage and occupancy count.
// A pop is honoured only when non-empty; a push is honoured when not full
// or when a pop frees the slot in the same cycle. The head output reads
// zero while empty so nothing undefined leaks out after reset.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_en, pop_en;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Qualify requests and compute next pointers and occupancy.
    always_comb begin
        pop_en   = pop_i && !empty_o;
        push_en  = push_i && (!full_o || pop_en);
        wr_ptr_d = push_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset since data_o is gated by empty.
    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/sim_console.sv
// Memory-mapped console/halt peripheral: TX byte FIFO streamed over a
// valid/ready port, sticky overflow flag, and a first-write-wins halt latch.
//
// Byte port handshake: tx_valid means tx_data holds the FIFO head; a byte
// transfers on any rising edge where tx_valid && tx_ready, and tx_data stays
// stable while tx_valid is high and tx_ready is low.
module sim_console
    import sim_console_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_we,
    input  logic        mem_re,
    output logic [31:0] mem_rdata,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        halted,
    output logic [7:0]  exit_code
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          hit;
    logic [1:0]    ofs;
    logic          wr_tx, wr_halt, wr_clear;
    logic          tx_pop;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0]   rd_value;

    logic          overflow_q, overflow_d;
    logic          halted_q, halted_d;
    logic [7:0]    exit_code_q, exit_code_d;
    logic [31:0]   rdata_q, rdata_d;

    // Address bits below word granularity and upper store bytes are ignored.
    logic unused_bits;
    assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:8]};

    assign hit      = (mem_addr[31:4] == BASE_ADDR[31:4]);
    assign ofs      = mem_addr[3:2];
    assign wr_tx    = mem_we && hit && (ofs == OFS_TXDATA);
    assign wr_halt  = mem_we && hit && (ofs == OFS_HALT);
    assign wr_clear = mem_we && hit && (ofs == OFS_CLEAR);
    assign tx_valid = !fifo_empty;
    assign tx_pop   = tx_valid && tx_ready;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (wr_tx),
        .data_i  (mem_wdata[7:0]),
        .pop_i   (tx_ready),
        .data_o  (tx_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Register read mux; reflects state from before the current edge.
    always_comb begin
        rd_value = '0;
        case (ofs)
            OFS_STATUS: rd_value = pack_status(8'(fifo_count), fifo_full,
                                               fifo_empty, overflow_q, halted_q);
            OFS_HALT:   rd_value = {24'b0, exit_code_q};
            default:    rd_value = '0;
        endcase
    end

    // Next state for flags, halt latch and registered load data.
    always_comb begin
        overflow_d  = overflow_q;
        halted_d    = halted_q;
        exit_code_d = exit_code_q;
        rdata_d     = rdata_q;
        if (wr_tx && fifo_full && !tx_pop) begin
            overflow_d = 1'b1;
        end
        if (wr_clear) begin
            overflow_d = 1'b0;
        end
        if (wr_halt && !halted_q) begin
            halted_d    = 1'b1;
            exit_code_d = mem_wdata[7:0];
        end
        if (mem_re) begin
            rdata_d = hit ? rd_value : '0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow_q  <= 1'b0;
            halted_q    <= 1'b0;
            exit_code_q <= '0;
            rdata_q     <= '0;
        end else begin
            overflow_q  <= overflow_d;
            halted_q    <= halted_d;
            exit_code_q <= exit_code_d;
            rdata_q     <= rdata_d;
        end
    end

    assign mem_rdata = rdata_q;
    assign halted    = halted_q;
    assign exit_code = exit_code_q;

endmodule
